// File: rtl/fpu_result_arbiter.sv
// Round-robin collector of FPU unit results into one registered output slot.
// Optional sticky accrued-exception register is enabled by defining FPU_FFLAGS_ACC_EN.
module fpu_result_arbiter #(
  parameter  int unsigned N_UNITS = 4,
  localparam int unsigned PTR_W   = $clog2(N_UNITS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [N_UNITS-1:0]     valid_in,
  output logic [N_UNITS-1:0]     ready_out,
  input  logic [32*N_UNITS-1:0]  result_in,
  input  logic [5*N_UNITS-1:0]   flags_in,
  output logic                   valid_out,
  input  logic                   ready_in,
  output logic [31:0]            result_out,
  output logic [4:0]             flags_out,
  output logic [PTR_W-1:0]       unit_out
`ifdef FPU_FFLAGS_ACC_EN
  ,
  input  logic                   fflags_clr,
  output logic [4:0]             fflags_acc
`endif
);

  localparam int unsigned RES_W = 32;
  localparam int unsigned FLG_W = 5;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   scan_idx;
  logic [N_UNITS-1:0] grant;
  logic               grant_any;
  int unsigned        scan_pos;
  logic [RES_W-1:0]   grant_result;
  logic [FLG_W-1:0]   grant_flags;
  logic               slot_free;
  logic               accept_en;
  logic               accept;
  logic               pop;

  // Round-robin search starting at rr_ptr, ascending with wrap
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan_pos  = 0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < N_UNITS; k++) begin
      scan_pos = 32'(rr_ptr) + k;
      if (scan_pos >= N_UNITS) begin
        scan_pos = scan_pos - N_UNITS;
      end
      scan_idx = PTR_W'(scan_pos);
      if (!grant_any && valid_in[scan_idx]) begin
        grant_any        = 1'b1;
        grant[scan_idx]  = 1'b1;
        grant_idx        = scan_idx;
      end
    end
  end

  // Payload mux for the granted unit
  always_comb begin
    grant_result = '0;
    grant_flags  = '0;
    for (int unsigned i = 0; i < N_UNITS; i++) begin
      if (grant[i]) begin
        grant_result = result_in[RES_W*i +: RES_W];
        grant_flags  = flags_in[FLG_W*i +: FLG_W];
      end
    end
  end

  assign slot_free = (state == EMPTY) || ready_in;
  assign accept_en = slot_free && !flush && !reset;
  assign ready_out = grant & {N_UNITS{accept_en}};
  assign accept    = grant_any && accept_en;
  assign valid_out = (state == FULL) && !flush;
  assign pop       = valid_out && ready_in;

  // Slot occupancy next-state
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else if (accept) begin
      state_nxt = FULL;
    end else if (pop) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Output slot payload and round-robin pointer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_out <= '0;
      flags_out  <= '0;
      unit_out   <= '0;
      rr_ptr     <= '0;
    end else if (flush) begin
      result_out <= '0;
      flags_out  <= '0;
    end else if (accept) begin
      result_out <= grant_result;
      flags_out  <= grant_flags;
      unit_out   <= grant_idx;
      rr_ptr     <= (grant_idx == PTR_W'(N_UNITS - 1)) ? '0 : grant_idx + PTR_W'(1);
    end else if (pop) begin
      result_out <= '0;
      flags_out  <= '0;
    end
  end

`ifdef FPU_FFLAGS_ACC_EN
  // Sticky accrued exceptions; a clear keeps the flags popped in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fflags_acc <= '0;
    end else if (fflags_clr) begin
      fflags_acc <= pop ? flags_out : '0;
    end else if (pop) begin
      fflags_acc <= fflags_acc | flags_out;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_result_arbiter.sv
// Self-checking bench for fpu_result_arbiter (N_UNITS=4): per-cycle model compare plus
// directed literal checks. Define FPU_FFLAGS_ACC_EN to also exercise the accrued flags.
module tb_fpu_result_arbiter;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic [N-1:0]    valid_in;
  logic [N-1:0]    ready_out;
  logic [32*N-1:0] result_in;
  logic [5*N-1:0]  flags_in;
  logic            valid_out;
  logic            ready_in;
  logic [31:0]     result_out;
  logic [4:0]      flags_out;
  logic [1:0]      unit_out;
`ifdef FPU_FFLAGS_ACC_EN
  logic            fflags_clr;
  logic [4:0]      fflags_acc;
`endif

  logic [31:0] res_u [N];
  logic [4:0]  flg_u [N];

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign result_in[32*i +: 32] = res_u[i];
    assign flags_in[5*i +: 5]    = flg_u[i];
  end

  fpu_result_arbiter #(.N_UNITS(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .result_in  (result_in),
    .flags_in   (flags_in),
    .valid_out  (valid_out),
    .ready_in   (ready_in),
    .result_out (result_out),
    .flags_out  (flags_out),
    .unit_out   (unit_out)
`ifdef FPU_FFLAGS_ACC_EN
    ,
    .fflags_clr (fflags_clr),
    .fflags_acc (fflags_acc)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Abstract model: one slot, a pointer, and an accrued-flags word
  logic        m_valid;
  logic [31:0] m_result;
  logic [4:0]  m_flags;
  int          m_unit;
  int          m_ptr;
  logic [4:0]  m_acc;

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    logic [N-1:0] sh;
    for (int k = 0; k < N; k++) begin
      sh = v >> ((ptr + k) % N);
      if (sh[0]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid = 1'b0; m_result = '0; m_flags = '0; m_unit = 0; m_ptr = 0; m_acc = '0;
    end else begin : upd
      int   g;
      logic hs;
      g  = pick(valid_in, m_ptr);
      hs = m_valid && !flush && ready_in;
`ifdef FPU_FFLAGS_ACC_EN
      if (fflags_clr) m_acc = hs ? m_flags : 5'd0;
      else if (hs)    m_acc = m_acc | m_flags;
`endif
      if (flush) begin
        m_valid = 1'b0; m_result = '0; m_flags = '0;
      end else if (g >= 0 && (!m_valid || ready_in)) begin
        m_valid = 1'b1; m_result = res_u[g]; m_flags = flg_u[g]; m_unit = g; m_ptr = (g + 1) % N;
      end else if (hs) begin
        m_valid = 1'b0; m_result = '0; m_flags = '0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin : cmp
    int           g;
    logic [N-1:0] er;
    g  = pick(valid_in, m_ptr);
    er = '0;
    if (!reset && !flush && (!m_valid || ready_in) && g >= 0) er = N'(1) << g;
    chk("m_valid_out", 32'(valid_out), 32'(m_valid && !flush));
    chk("m_ready_out", 32'(ready_out), 32'(er));
    chk("m_result_out", result_out, m_result);
    chk("m_flags_out", 32'(flags_out), 32'(m_flags));
    if (m_valid) chk("m_unit_out", 32'(unit_out), 32'(m_unit));
`ifdef FPU_FFLAGS_ACC_EN
    chk("m_fflags_acc", 32'(fflags_acc), 32'(m_acc));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic r, input logic f);
    valid_in = v;
    ready_in = r;
    flush    = f;
  endtask

  logic [N-1:0] tv_v [11] = '{4'b1010, 4'b1010, 4'b0110, 4'b0000, 4'b0000, 4'b1111,
                              4'b1111, 4'b1000, 4'b0001, 4'b0001, 4'b0000};
  logic         tv_r [11] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  logic         tv_f [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    reset = 1'b0;
    drive(4'b1111, 1'b0, 1'b0);
`ifdef FPU_FFLAGS_ACC_EN
    fflags_clr = 1'b0;
`endif
    for (int i = 0; i < N; i++) begin
      res_u[i] = 32'hC0DE_0000 + 32'(i * 16 + 5);
      flg_u[i] = 5'(1 << i);
    end
    #1 reset = 1'b1;
    #1;
    chk("reset_valid_out", 32'(valid_out), 32'd0);
    chk("reset_ready_out", 32'(ready_out), 32'd0);
    chk("reset_result_out", result_out, 32'd0);
    chk("reset_flags_out", 32'(flags_out), 32'd0);
    chk("reset_unit_out", 32'(unit_out), 32'd0);
    tick();
    tick();
    reset = 1'b0;

    // Fairness: all units valid, sink always ready
    drive(4'b1111, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("fair_unit", 32'(unit_out), 32'(i % 4));
      chk("fair_valid", 32'(valid_out), 32'd1);
    end

    // Single unit, popping the previous result in the same cycle
    res_u[2] = 32'h1;
    flg_u[2] = 5'b10000;
    drive(4'b0100, 1'b1, 1'b0);
    tick();
    chk("single_valid", 32'(valid_out), 32'd1);
    chk("single_result", result_out, 32'h1);
    chk("single_flags", 32'(flags_out), 32'b10000);
    chk("single_unit", 32'(unit_out), 32'd2);
    drive(4'b0000, 1'b1, 1'b0);
    tick();
    chk("pop_valid", 32'(valid_out), 32'd0);
    chk("pop_result", result_out, 32'd0);

    // Backpressure: pointer is 3, so units {0,1} resolve to 0 first
    drive(4'b0011, 1'b0, 1'b0);
    tick();
    chk("bp_first_unit", 32'(unit_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready_out", 32'(ready_out), 32'd0);
      tick();
      chk("bp_result", result_out, res_u[0]);
      chk("bp_valid", 32'(valid_out), 32'd1);
    end
    drive(4'b0011, 1'b1, 1'b0);
    #1 chk("bp_release_ready", 32'(ready_out), 32'b0010);
    tick();
    chk("bp_next_unit", 32'(unit_out), 32'd1);

    // Flush while full: pointer must stay at 2
    drive(4'b0011, 1'b1, 1'b1);
    #1;
    chk("flush_valid_out", 32'(valid_out), 32'd0);
    chk("flush_ready_out", 32'(ready_out), 32'd0);
    tick();
    drive(4'b0000, 1'b0, 1'b0);
    #1;
    chk("flush_empty", 32'(valid_out), 32'd0);
    chk("flush_cleared", result_out, 32'd0);
    drive(4'b0011, 1'b1, 1'b0);
    #1 chk("flush_ptr_held", 32'(ready_out), 32'b0001);
    tick();
    chk("after_flush_unit", 32'(unit_out), 32'd0);

    // Reset mid-transfer: pointer would be 1 without reset
    drive(4'b1001, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("midrst_valid_out", 32'(valid_out), 32'd0);
    chk("midrst_result", result_out, 32'd0);
    chk("midrst_flags", 32'(flags_out), 32'd0);
    chk("midrst_unit", 32'(unit_out), 32'd0);
    chk("midrst_ready", 32'(ready_out), 32'd0);
    tick();
    reset = 1'b0;
    #1 chk("postrst_ready", 32'(ready_out), 32'b0001);
    tick();
    chk("postrst_unit", 32'(unit_out), 32'd0);

    // Mixed directed vectors, checked by the model every cycle
    for (int i = 0; i < 11; i++) begin
      drive(tv_v[i], tv_r[i], tv_f[i]);
      tick();
    end

`ifdef FPU_FFLAGS_ACC_EN
    flg_u[0] = 5'b10000;
    flg_u[1] = 5'b00001;
    flg_u[2] = 5'b00100;
    drive(4'b0000, 1'b1, 1'b0);
    tick();
    drive(4'b0000, 1'b0, 1'b0);
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    chk("acc_cleared", 32'(fflags_acc), 32'd0);
    drive(4'b0001, 1'b1, 1'b0);
    tick();
    drive(4'b0010, 1'b1, 1'b0);
    tick();
    drive(4'b0000, 1'b1, 1'b0);
    tick();
    chk("acc_or", 32'(fflags_acc), 32'b10001);
    drive(4'b0100, 1'b1, 1'b0);
    tick();
    drive(4'b0000, 1'b1, 1'b0);
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    chk("acc_clr_keep", 32'(fflags_acc), 32'b00100);
    drive(4'b0000, 1'b0, 1'b1);
    tick();
    chk("acc_flush_keep", 32'(fflags_acc), 32'b00100);
`endif

    drive(4'b0000, 1'b1, 1'b0);
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
